segment_stepper: RTL and testbench

- Consumes motion segments from the segment FIFO and turns each one into timed step pulses for one axis.
- Uses a fixed-point phase accumulator clocked by an internal sample tick.
- Ramps speed toward the segment's target speed by adding the segment's acceleration once per sample.
- Sits directly downstream of the motion-segment FIFO filled by CMD_WRITE_FIFO, and drives the step output pin.

---
 rtl/segment_stepper.sv | 224 ++++++++++++++++++++++
 tb/tb_segment_stepper.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_stepper.sv
`default_nettype none
// ============================================================================
// Module   : segment_stepper
// Brief    : Turns motion segments popped from the segment FIFO into timed
//            step pulses for one axis. A fixed-point phase accumulator is
//            advanced once per internal sample tick; speed ramps toward the
//            segment target by the segment acceleration on every tick.
// Revision : 1.0 - initial release
// ============================================================================
module segment_stepper #(
   parameter int SAMPLE_DIV   = 4,   // clocks per sample tick (>= 2)
   parameter int PULSE_CYCLES = 2,   // step pulse high time (1 .. SAMPLE_DIV-1)
   parameter int FRAC_BITS    = 16   // fractional bits of speed / accel
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] seg_i,
   input  logic         seg_valid_i,
   output logic         seg_ready_o,
   input  logic         abort_i,
   output logic         step_o,
   output logic         busy_o,
   output logic [31:0]  steps_done_o,
   output logic [31:0]  speed_o
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_div_w   = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
   localparam int c_pulse_w = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(SAMPLE_DIV - 1);
   localparam logic [c_pulse_w-1:0] c_pulse_last = c_pulse_w'(PULSE_CYCLES - 1);

   // Largest representable speed: just under one step per sample.
   localparam logic [31:0] c_speed_max = 32'((64'd1 << FRAC_BITS) - 64'd1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   state_t                 r_state;
   logic [c_div_w-1:0]     r_div;
   logic [31:0]            r_target_steps;
   logic [31:0]            r_target_speed;
   logic [31:0]            r_accel;
   logic [31:0]            r_speed;
   logic [FRAC_BITS-1:0]   r_phase;
   logic [31:0]            r_steps_done;
   logic                   r_step;
   logic [c_pulse_w-1:0]   r_pulse_cnt;

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic                   w_tick;
   logic                   w_accept;
   logic [31:0]            w_seg_target_steps;
   logic [31:0]            w_seg_current_speed;
   logic [31:0]            w_seg_target_speed;
   logic [31:0]            w_seg_accel;
   logic [31:0]            w_load_speed;
   logic [FRAC_BITS:0]     w_phase_sum;
   logic                   w_carry;
   logic [31:0]            w_steps_next;
   logic                   w_seg_complete;
   logic                   w_pulse_start;
   logic signed [32:0]     w_speed_sum;
   logic signed [32:0]     w_speed_tgt;
   logic signed [32:0]     w_speed_sel;
   logic [31:0]            w_speed_next;

   // Segment fields, packed exactly like the host motion_segment_t.
   assign w_seg_target_steps  = seg_i[31:0];
   assign w_seg_current_speed = seg_i[63:32];
   assign w_seg_target_speed  = seg_i[95:64];
   assign w_seg_accel         = seg_i[127:96];

   // The entry speed is clamped so the accumulator never carries twice per tick.
   assign w_load_speed = (w_seg_current_speed > c_speed_max) ? c_speed_max
                                                             : w_seg_current_speed;

   // Ready is held low while in reset and while an abort is requested so a
   // segment can never be popped and then silently discarded.
   assign seg_ready_o = rst_n && (r_state == IDLE) && !abort_i;
   assign w_accept    = seg_valid_i && seg_ready_o;

   assign w_tick = (r_div == c_div_last);

   // Phase accumulator: only the fractional part of speed contributes, so the
   // carry out is the step event and the phase stays masked to FRAC_BITS.
   assign w_phase_sum = {1'b0, r_phase} + {1'b0, r_speed[FRAC_BITS-1:0]};
   assign w_carry     = w_phase_sum[FRAC_BITS];

   assign w_steps_next   = r_steps_done + 32'd1;
   assign w_seg_complete = w_carry && (w_steps_next == r_target_steps);

   // A pulse starts only on a carrying tick that is not overridden by abort.
   assign w_pulse_start = (r_state == RUN) && !abort_i && w_tick && w_carry;

   // Speed ramp: 33-bit signed arithmetic so neither direction can wrap,
   // followed by a clamp into 0 .. c_speed_max.
   always_comb begin
      w_speed_sum  = $signed({1'b0, r_speed}) + $signed({r_accel[31], r_accel});
      w_speed_tgt  = $signed({1'b0, r_target_speed});
      w_speed_sel  = $signed({1'b0, r_speed});
      w_speed_next = r_speed;

      if (r_accel[31]) begin
         // Decelerating: do not go below the target.
         w_speed_sel = (w_speed_sum < w_speed_tgt) ? w_speed_tgt : w_speed_sum;
      end else if (r_accel != 32'd0) begin
         // Accelerating: do not go above the target.
         w_speed_sel = (w_speed_sum > w_speed_tgt) ? w_speed_tgt : w_speed_sum;
      end

      if (w_speed_sel[32]) begin
         w_speed_next = 32'd0;
      end else if (w_speed_sel > $signed({1'b0, c_speed_max})) begin
         w_speed_next = c_speed_max;
      end else begin
         w_speed_next = w_speed_sel[31:0];
      end
   end

   // -------------------------------------------------------------------------
   // Free-running sample divider; segment loads never disturb its phase.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + c_div_w'(1);
      end
   end

   // -------------------------------------------------------------------------
   // Segment FSM: load in IDLE, accumulate and ramp on ticks in RUN.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_target_steps <= '0;
         r_target_speed <= '0;
         r_accel        <= '0;
         r_speed        <= '0;
         r_phase        <= '0;
         r_steps_done   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_target_steps <= w_seg_target_steps;
                  r_target_speed <= w_seg_target_speed;
                  r_accel        <= w_seg_accel;
                  r_speed        <= w_load_speed;
                  r_phase        <= '0;
                  r_steps_done   <= '0;
                  // A zero-step segment is consumed without ever running.
                  r_state        <= (w_seg_target_steps != 32'd0) ? RUN : IDLE;
               end
            end

            RUN: begin
               if (abort_i) begin
                  // Abort wins over a coincident tick; step count is kept.
                  r_state <= IDLE;
                  r_speed <= '0;
               end else if (w_tick) begin
                  r_phase <= w_phase_sum[FRAC_BITS-1:0];
                  r_speed <= w_speed_next;
                  if (w_carry) begin
                     r_steps_done <= w_steps_next;
                  end
                  if (w_seg_complete) begin
                     r_state <= IDLE;
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Step pulse generator: fixed-width pulse that runs to completion even if
   // the segment finishes or is aborted underneath it.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step      <= 1'b0;
         r_pulse_cnt <= '0;
      end else if (w_pulse_start) begin
         r_step      <= 1'b1;
         r_pulse_cnt <= c_pulse_last;
      end else if (r_step) begin
         if (r_pulse_cnt == '0) begin
            r_step <= 1'b0;
         end else begin
            r_pulse_cnt <= r_pulse_cnt - c_pulse_w'(1);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign step_o       = r_step;
   assign busy_o       = (r_state == RUN);
   assign steps_done_o = r_steps_done;
   assign speed_o      = r_speed;

endmodule
`default_nettype wire

// File: tb/tb_segment_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_stepper
// Brief    : Directed self-checking bench for segment_stepper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_stepper;

   logic         clk;
   logic         rst_n;
   logic [127:0] seg_i;
   logic         seg_valid_i;
   logic         seg_ready_o;
   logic         abort_i;
   logic         step_o;
   logic         busy_o;
   logic [31:0]  steps_done_o;
   logic [31:0]  speed_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pops   = 0;
   int pulses = 0;

   segment_stepper #(
      .SAMPLE_DIV   (4),
      .PULSE_CYCLES (2),
      .FRAC_BITS    (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_i        (seg_i),
      .seg_valid_i  (seg_valid_i),
      .seg_ready_o  (seg_ready_o),
      .abort_i      (abort_i),
      .step_o       (step_o),
      .busy_o       (busy_o),
      .steps_done_o (steps_done_o),
      .speed_o      (speed_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock count since reset release: with SAMPLE_DIV=4 the tick updates
   // become visible just after every edge where cyc is a multiple of 4.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      if (seg_valid_i && seg_ready_o) pops <= pops + 1;
   end

   always @(posedge step_o) pulses <= pulses + 1;

   function automatic logic [127:0] mk_seg(input logic [31:0] steps,
                                           input logic [31:0] cur,
                                           input logic [31:0] tgt,
                                           input logic [31:0] acc);
      return {acc, tgt, cur, steps};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clk1;
      @(posedge clk);
      #1;
   endtask

   // Advance to just after the next edge that carries a sample tick.
   task automatic to_tick;
      int n;
      n = 0;
      do begin
         clk1;
         n++;
      end while (((cyc % 4) != 0) && (n < 8));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while (busy_o && (n < budget)) begin
         clk1;
         n++;
      end
      chk(tag, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic wait_step_low;
      int n;
      n = 0;
      while (step_o && (n < 10)) begin
         clk1;
         n++;
      end
   endtask

   int          load_cyc, t1, nr, hi, p0, pl, npop, fall, bad_ready, n;
   int          rise[4];
   logic        prev, busy_at4, busy_before4, prev_busy, will;
   int          pop_c[2];
   logic [127:0] q[$];

   initial begin
      rst_n       = 1'b0;
      seg_i       = '0;
      seg_valid_i = 1'b0;
      abort_i     = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      chk("rst_step",  {31'd0, step_o}, 32'd0);
      chk("rst_busy",  {31'd0, busy_o}, 32'd0);
      chk("rst_ready", {31'd0, seg_ready_o}, 32'd0);
      chk("rst_done",  steps_done_o, 32'd0);
      chk("rst_speed", speed_o, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_ready", {31'd0, seg_ready_o}, 32'd1);

      // ---------------- constant speed ----------------
      p0 = pops;
      seg_i = mk_seg(32'd4, 32'h8000, 32'h8000, 32'd0);
      seg_valid_i = 1'b1;
      clk1;
      seg_valid_i = 1'b0;
      load_cyc = cyc;
      chk("t1_pop", pops, p0 + 1);
      chk("t1_busy", {31'd0, busy_o}, 32'd1);
      t1 = ((load_cyc / 4) + 1) * 4;
      nr = 0; hi = 0; prev = 1'b0; prev_busy = busy_o;
      busy_at4 = 1'b1; busy_before4 = 1'b0;
      for (int i = 0; i < 60; i++) begin
         clk1;
         if (step_o && !prev) begin
            if (nr < 4) rise[nr] = cyc;
            if (nr == 3) begin
               busy_at4     = busy_o;
               busy_before4 = prev_busy;
            end
            nr++;
         end
         if (step_o) hi++;
         prev = step_o;
         prev_busy = busy_o;
      end
      chk("t1_npulse", nr, 4);
      chk("t1_first_rise", rise[0], t1 + 4);
      chk("t1_gap1", rise[1] - rise[0], 8);
      chk("t1_gap2", rise[2] - rise[1], 8);
      chk("t1_gap3", rise[3] - rise[2], 8);
      chk("t1_high_clocks", hi, 8);
      chk("t1_busy_before_last", {31'd0, busy_before4}, 32'd1);
      chk("t1_busy_at_last", {31'd0, busy_at4}, 32'd0);
      chk("t1_done", steps_done_o, 32'd4);
      chk("t1_one_pop", pops, p0 + 1);

      // ---------------- acceleration clamp ----------------
      seg_i = mk_seg(32'd4, 32'h4000, 32'h10000, 32'h4000);
      seg_valid_i = 1'b1;
      clk1;
      seg_valid_i = 1'b0;
      to_tick; chk("t2_speed1", speed_o, 32'h8000);
      to_tick; chk("t2_speed2", speed_o, 32'h C000);
      to_tick; chk("t2_speed3", speed_o, 32'hFFFF);
      to_tick; chk("t2_speed4", speed_o, 32'hFFFF);
      wait_idle("t2_finish", 100);
      chk("t2_done", steps_done_o, 32'd4);
      wait_step_low;

      // ---------------- deceleration floor and abort ----------------
      seg_i = mk_seg(32'd5, 32'h2000, 32'd0, 32'hFFFF_D000);
      seg_valid_i = 1'b1;
      clk1;
      seg_valid_i = 1'b0;
      pl = pulses;
      to_tick;
      chk("t3_speed_floor", speed_o, 32'd0);
      repeat (20) clk1;
      chk("t3_stalled_busy", {31'd0, busy_o}, 32'd1);
      chk("t3_no_pulse", pulses, pl);
      chk("t3_speed_hold", speed_o, 32'd0);
      abort_i = 1'b1;
      #1;
      chk("t3_ready_run_abort", {31'd0, seg_ready_o}, 32'd0);
      clk1;
      abort_i = 1'b0;
      chk("t3_abort_idle", {31'd0, busy_o}, 32'd0);
      chk("t3_abort_speed", speed_o, 32'd0);
      chk("t3_abort_done", steps_done_o, 32'd0);
      repeat (10) clk1;
      chk("t3_no_pulse_after", pulses, pl);
      p0 = pops;
      seg_i = mk_seg(32'd1, 32'hFFFF, 32'hFFFF, 32'd0);
      seg_valid_i = 1'b1;
      abort_i = 1'b1;
      #1;
      chk("t3_idle_abort_ready", {31'd0, seg_ready_o}, 32'd0);
      clk1;
      chk("t3_idle_abort_nopop", pops, p0);
      seg_valid_i = 1'b0;
      abort_i = 1'b0;
      clk1;

      // ---------------- zero-step then back-to-back ----------------
      p0 = pops;
      pl = pulses;
      seg_i = mk_seg(32'd0, 32'h1000, 32'h1000, 32'd0);
      seg_valid_i = 1'b1;
      clk1;
      chk("t4_zero_pop", pops, p0 + 1);
      chk("t4_zero_busy", {31'd0, busy_o}, 32'd0);
      seg_i = mk_seg(32'd1, 32'hFFFF, 32'hFFFF, 32'd0);
      clk1;
      seg_valid_i = 1'b0;
      chk("t4_second_pop", pops, p0 + 2);
      chk("t4_second_busy", {31'd0, busy_o}, 32'd1);
      chk("t4_zero_no_pulse", pulses, pl);
      wait_idle("t4_finish", 100);
      chk("t4_done", steps_done_o, 32'd1);
      wait_step_low;
      chk("t4_one_pulse", pulses, pl + 1);

      // ---------------- back-to-back FIFO ----------------
      q.push_back(mk_seg(32'd2, 32'h8000, 32'h8000, 32'd0));
      q.push_back(mk_seg(32'd2, 32'h8000, 32'h8000, 32'd0));
      pl = pulses; npop = 0; fall = -1; bad_ready = 0;
      pop_c[0] = 0; pop_c[1] = 0;
      prev_busy = busy_o;
      for (int i = 0; i < 80; i++) begin
         seg_valid_i = (q.size() != 0);
         seg_i = (q.size() != 0) ? q[0] : '0;
         #1;
         will = seg_valid_i && seg_ready_o;
         if (busy_o && seg_ready_o) bad_ready++;
         clk1;
         if (will) begin
            q.delete(0);
            if (npop < 2) pop_c[npop] = cyc;
            npop++;
         end
         if (prev_busy && !busy_o && (fall < 0)) fall = cyc;
         prev_busy = busy_o;
      end
      seg_valid_i = 1'b0;
      chk("t5_npop", npop, 2);
      chk("t5_second_pop_gap", pop_c[1], fall + 1);
      chk("t5_ready_low_in_run", bad_ready, 0);
      chk("t5_pulses", pulses, pl + 4);
      chk("t5_done", steps_done_o, 32'd2);

      // ---------------- reset mid-pulse ----------------
      seg_i = mk_seg(32'd3, 32'hFFFF, 32'hFFFF, 32'd0);
      seg_valid_i = 1'b1;
      clk1;
      seg_valid_i = 1'b0;
      n = 0;
      while (!step_o && (n < 30)) begin
         clk1;
         n++;
      end
      chk("t6_pulse_seen", {31'd0, step_o}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_step", {31'd0, step_o}, 32'd0);
      chk("t6_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("t6_rst_speed", speed_o, 32'd0);
      chk("t6_rst_done", steps_done_o, 32'd0);
      chk("t6_rst_ready", {31'd0, seg_ready_o}, 32'd0);
      clk1;
      clk1;
      p0 = pops;
      rst_n = 1'b1;
      #1;
      chk("t6_ready_after", {31'd0, seg_ready_o}, 32'd1);
      repeat (5) clk1;
      chk("t6_no_pop", pops, p0);
      chk("t6_idle", {31'd0, busy_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
